// File: rtl/rv_constants.sv
// Shared RISC-V constants: ALU operation codes plus the iterative ALU's
// FSM state and shift-kind enumerations.
package rv_constants;

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_SEQ  = 5'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_iter_state_t;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational single-cycle ALU operations (no shifts); any code it
// does not implement yields a zero result and raises illegal.
module alu_core
    import rv_constants::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       alu_function,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    // Operation select; shift codes fall to default and are handled upstream.
    always_comb begin
        result  = {WIDTH{1'b0}};
        illegal = 1'b0;
        case (alu_function)
            ALU_ADD:  result = operand_a + operand_b;
            ALU_SUB:  result = operand_a - operand_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            ALU_SEQ:  result = {{(WIDTH-1){1'b0}}, (operand_a == operand_b)};
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_OR:   result = operand_a | operand_b;
            ALU_AND:  result = operand_a & operand_b;
            default: begin
                result  = {WIDTH{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle ops via alu_core, shifts via an iterative
// shifter moving up to SHIFT_STEP bits per cycle, valid/ready on both sides.
module alu_iterative
    import rv_constants::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_function,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_zero,
    output logic             illegal
);

    localparam int            SW     = $clog2(WIDTH);
    localparam logic [SW:0]   STEP_K = SHIFT_STEP[SW:0];

    alu_iter_state_t  state_r, state_next_s;
    shift_kind_t      kind_r, kind_s;
    logic [WIDTH-1:0] result_r, core_result_s, shifted_s, load_result_s;
    logic [SW-1:0]    remaining_r, shamt_s;
    logic [SW:0]      k_s;
    logic             result_zero_r, illegal_r, out_valid_r, core_illegal_s;
    logic             is_shift_s, start_shift_s, accept_s, in_ready_s, last_step_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_function (alu_function),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .result       (core_result_s),
        .illegal      (core_illegal_s)
    );

    // Request decode: shift detection and the value loaded at accept.
    always_comb begin
        is_shift_s = 1'b1;
        kind_s     = SK_SLL;
        shamt_s    = operand_b[SW-1:0];
        case (alu_function)
            ALU_SLL: kind_s = SK_SLL;
            ALU_SRL: kind_s = SK_SRL;
            ALU_SRA: kind_s = SK_SRA;
            default: is_shift_s = 1'b0;
        endcase
        start_shift_s = is_shift_s && (shamt_s != {SW{1'b0}});
        load_result_s = is_shift_s ? operand_a : core_result_s;
    end

    // Handshake: ready depends only on state and out_ready, never in_valid.
    always_comb begin
        in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // One shifter step; SRA keeps replicating the sign bit it started with.
    always_comb begin
        if ({1'b0, remaining_r} < STEP_K) begin
            k_s = {1'b0, remaining_r};
        end else begin
            k_s = STEP_K;
        end
        last_step_s = ({1'b0, remaining_r} == k_s);
        case (kind_r)
            SK_SLL:  shifted_s = result_r << k_s;
            SK_SRL:  shifted_s = result_r >> k_s;
            SK_SRA:  shifted_s = $signed(result_r) >>> k_s;
            default: shifted_s = result_r;
        endcase
    end

    // Next-state logic; DONE with out_ready may accept the next request directly.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = start_shift_s ? SHIFT : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_next_s = start_shift_s ? SHIFT : DONE;
                end else if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, result and shift counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            kind_r        <= SK_SLL;
            result_r      <= {WIDTH{1'b0}};
            result_zero_r <= 1'b0;
            illegal_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            remaining_r   <= {SW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == DONE);
            if (accept_s) begin
                result_r      <= load_result_s;
                result_zero_r <= (load_result_s == {WIDTH{1'b0}});
                illegal_r     <= is_shift_s ? 1'b0 : core_illegal_s;
                remaining_r   <= start_shift_s ? shamt_s : {SW{1'b0}};
                kind_r        <= kind_s;
            end else if (state_r == SHIFT) begin
                result_r      <= shifted_s;
                result_zero_r <= (shifted_s == {WIDTH{1'b0}});
                remaining_r   <= remaining_r - k_s[SW-1:0];
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign result_zero = result_zero_r;
    assign illegal     = illegal_r;

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: directed requests push expected
// responses, a forked monitor pops and compares on each output handshake.
module tb_alu_iterative;
    import rv_constants::*;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, result_zero, illegal;
    logic [4:0]  alu_function;
    logic [31:0] operand_a, operand_b, result;

    logic        in4_valid, in4_ready, out4_valid, out4_ready, result4_zero, illegal4;
    logic [4:0]  alu4_function;
    logic [31:0] operand4_a, operand4_b, result4;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   next_id = 1;

    alu_iterative #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_function (alu_function),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .result_zero  (result_zero),
        .illegal      (illegal)
    );

    alu_iterative #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in4_valid),
        .in_ready     (in4_ready),
        .alu_function (alu4_function),
        .operand_a    (operand4_a),
        .operand_b    (operand4_b),
        .out_valid    (out4_valid),
        .out_ready    (out4_ready),
        .result       (result4),
        .result_zero  (result4_zero),
        .illegal      (illegal4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s (item %0d): actual=%h required=%h", name, id, act, expv);
        end
    endtask

    // Drive one request, wait (bounded) for in_ready, push expectation at accept.
    task automatic issue(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei, input int lat);
        int   budget;
        exp_t e;
        budget       = 0;
        alu_function = fn;
        operand_a    = a;
        operand_b    = b;
        in_valid     = 1'b1;
        @(negedge clock);
        while (!in_ready && budget < 200) begin
            budget++;
            @(negedge clock);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout (item %0d): in_ready=%b required=1", next_id, in_ready);
            in_valid = 1'b0;
            next_id++;
        end else begin
            e.id   = next_id;
            e.res  = er;
            e.zero = ez;
            e.ill  = ei;
            e.acc  = cyc + 1;
            e.lat  = lat;
            exp_q.push_back(e);
            next_id++;
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_monitor();
        int   first;
        bit   seen;
        exp_t e;
        first = 0;
        seen  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    first = cyc;
                    seen  = 1'b1;
                end
                if (out_ready) begin
                    seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: actual result=%h, required no output", result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result",      e.id, result, e.res);
                        check("result_zero", e.id, {31'd0, result_zero}, {31'd0, e.zero});
                        check("illegal",     e.id, {31'd0, illegal}, {31'd0, e.ill});
                        check("latency",     e.id, first, e.acc + e.lat - 1);
                    end
                end
            end
        end
    endtask

    initial begin
        int edges;
        int w;
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        alu_function  = 5'd0;
        operand_a     = 32'd0;
        operand_b     = 32'd0;
        out_ready     = 1'b1;
        in4_valid     = 1'b0;
        alu4_function = 5'd0;
        operand4_a    = 32'd0;
        operand4_b    = 32'd0;
        out4_ready    = 1'b1;
        fork
            run_monitor();
        join_none

        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid",   0, {31'd0, out_valid},   32'd0);
        check("reset_result",      0, result,               32'd0);
        check("reset_result_zero", 0, {31'd0, result_zero}, 32'd0);
        check("reset_illegal",     0, {31'd0, illegal},     32'd0);
        check("reset_in_ready",    0, {31'd0, in_ready},    32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        issue(ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1);
        issue(ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1);
        check("in_ready_back_to_back", 0, {31'd0, in_ready}, 32'd1);
        issue(ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
        issue(ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1);
        issue(ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
        issue(ALU_SEQ,  32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 1);
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);

        issue(ALU_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        repeat (10) @(negedge clock);
        check("in_ready_mid_shift",  0, {31'd0, in_ready},  32'd0);
        check("out_valid_mid_shift", 0, {31'd0, out_valid}, 32'd0);
        issue(ALU_SLL,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0, 1);
        issue(ALU_SRL,  32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b0, 1'b0, 5);
        issue(ALU_SLL,  32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
        issue(ALU_SRL,  32'h0000_0001, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 2);

        // Output stall: result must hold and a pending request must be ignored.
        issue(ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1);
        out_ready    = 1'b0;
        alu_function = ALU_ADD;
        operand_a    = 32'd1;
        operand_b    = 32'd2;
        in_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_out_valid", i, {31'd0, out_valid}, 32'd1);
            check("stall_in_ready",  i, {31'd0, in_ready},  32'd0);
            check("stall_result",    i, result,             32'h0F0F_00F0);
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        issue(ALU_ADD,  32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);

        // Asynchronous reset in the middle of a 20-bit shift.
        issue(ALU_SRL,  32'hFFFF_FFFF, 32'd20, 32'h0000_0FFF, 1'b0, 1'b0, 21);
        repeat (5) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", 0, {31'd0, out_valid}, 32'd0);
        check("async_reset_result",    0, result,             32'd0);
        check("async_reset_in_ready",  0, {31'd0, in_ready},  32'd1);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_out_valid", 0, {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        #1;

        issue(5'd31, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1);
        issue(5'd0,  32'hDEAD_BEEF, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1);
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);

        // SHIFT_STEP=4 instance: SRA by 31 takes 1 + ceil(31/4) = 9 edges.
        alu4_function = ALU_SRA;
        operand4_a    = 32'h8000_0000;
        operand4_b    = 32'd31;
        in4_valid     = 1'b1;
        @(negedge clock);
        check("step4_in_ready", 0, {31'd0, in4_ready}, 32'd1);
        @(posedge clock);
        #1;
        in4_valid = 1'b0;
        edges     = 1;
        while (edges < 40) begin
            @(negedge clock);
            if (out4_valid) break;
            @(posedge clock);
            edges++;
        end
        check("step4_latency", 0, edges,                  32'd9);
        check("step4_result",  0, result4,                32'hFFFF_FFFF);
        check("step4_zero",    0, {31'd0, result4_zero},  32'd0);
        check("step4_illegal", 0, {31'd0, illegal4},      32'd0);

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clock);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
        end
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
